// File: rtl/reset_seq_pkg.sv
// Shared state and cause codes for the reset sequencer.
// Also holds a counter-width helper used by its modules.
package reset_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t WAIT_LOCK = 2'd0;
  localparam state_t HOLD      = 2'd1;
  localparam state_t RELEASE   = 2'd2;
  localparam state_t RUN       = 2'd3;

  localparam logic [1:0] CAUSE_RESET = 2'd0;
  localparam logic [1:0] CAUSE_LOCK  = 2'd1;
  localparam logic [1:0] CAUSE_SOFT  = 2'd2;
  localparam logic [1:0] CAUSE_WDOG  = 2'd3;

  // Bits needed to count 0..n-1 (at least 1).
  function automatic int cnt_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// STAGES-deep single-bit synchroniser, async clear to 0.
// Ports: clk, rst (async high), d (async in), q (synced out).
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release after PLL lock; re-asserts on
// lock loss, soft reset and (RESET_SEQ_WDOG_EN) watchdog.
// Ports: clk, reset (async high), pll_locked, soft_rst,
// wdog_kick (watchdog build only), rst_out, ready, cause.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_OUT        = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int WDOG_CYCLES    = 1048576
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_locked,
  input  logic               soft_rst,
`ifdef RESET_SEQ_WDOG_EN
  input  logic               wdog_kick,
`endif
  output logic [NUM_OUT-1:0] rst_out,
  output logic               ready,
  output logic [1:0]         cause
);

  localparam int CMAX =
    (HOLD_CYCLES > STAGGER_CYCLES) ?
    HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CW = cnt_bits(CMAX);
  localparam int IW = cnt_bits(NUM_OUT);

  localparam logic [CW-1:0] HOLD_LAST =
    CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST =
    CW'(STAGGER_CYCLES - 1);
  // idx of the bit released just before the last one
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NUM_OUT - 2);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          lock_s;
  logic          wdog_fire;
  logic          active;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(clk),
    .rst(reset),
    .d  (pll_locked),
    .q  (lock_s)
  );

  assign active = (state != WAIT_LOCK);

`ifdef RESET_SEQ_WDOG_EN
  localparam int WW = cnt_bits(WDOG_CYCLES);
  localparam logic [WW-1:0] WDOG_LAST =
    WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] wcnt;

  assign wdog_fire = (state == RUN) && !wdog_kick &&
                     (wcnt == WDOG_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wcnt <= '0;
    else if (state != RUN || wdog_kick || wdog_fire)
      wcnt <= '0;
    else
      wcnt <= wcnt + 1'b1;
  end
`else
  assign wdog_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= WAIT_LOCK;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
      cause   <= CAUSE_RESET;
    end else if (active && !lock_s) begin
      state   <= WAIT_LOCK;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
      cause   <= CAUSE_LOCK;
    end else if (active && soft_rst) begin
      state   <= HOLD;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
      cause   <= CAUSE_SOFT;
    end else if (wdog_fire) begin
      state   <= HOLD;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
      cause   <= CAUSE_WDOG;
    end else begin
      unique case (state)
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= HOLD;
            cnt   <= '0;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt     <= '0;
            idx     <= '0;
            // zero shifts in from the bottom: bit 0 first
            rst_out <= rst_out << 1;
            if (NUM_OUT == 1) begin
              state <= RUN;
              ready <= 1'b1;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt == STAG_LAST) begin
            cnt     <= '0;
            rst_out <= rst_out << 1;
            idx     <= idx + 1'b1;
            if (idx == IDX_LAST) begin
              state <= RUN;
              ready <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
        end
      endcase
    end
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumer end of the board/power-on reset: takes the raw asynchronous active-high reset plus PLL lock, and produces staged, synchronously released active-high resets for NUM_OUT downstream domains/blocks.
- Sits between the top-level reset source and the core/peripheral/bus reset nets.
- Handles soft reset requests and loss of lock by re-asserting every output and re-running the release sequence.

Parameters:
- NUM_OUT, 3, number of staged reset outputs; bit 0 is released first.
- SYNC_STAGES, 2, flop depth of the pll_locked synchroniser; minimum 2.
- HOLD_CYCLES, 16, cycles all outputs stay asserted after lock is seen; minimum 1.
- STAGGER_CYCLES, 4, cycles between successive output releases; minimum 1.
- WDOG_CYCLES, 1048576, watchdog timeout (optional feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset; deassertion need not be clock-aligned.
- pll_locked  in  1  asynchronous lock indication, synchronised internally.
- soft_rst  in  1  synchronous single-cycle soft reset request.
- rst_out  out  NUM_OUT  active-high staged resets, all driven from flops.
- ready  out  1  high when every rst_out bit is released.
- cause  out  2  last reset cause: 0 = reset, 1 = lock loss, 2 = soft, 3 = watchdog.
- wdog_kick  in  1  watchdog refresh; present only with RESET_SEQ_WDOG_EN.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high; all flops are cleared asynchronously by it.
- While reset is high:
  - rst_out = all ones, ready = 0, cause = 0.
  - Synchroniser flops = 0, counters = 0, state = WAIT_LOCK.
- lock_s is pll_locked after SYNC_STAGES flops.
- State WAIT_LOCK:
  - All rst_out held at 1.
  - When lock_s = 1: go to HOLD, cnt = 0.
- State HOLD:
  - cnt increments each cycle.
  - On the cycle cnt = HOLD_CYCLES-1: go to RELEASE, idx = 0, and rst_out[0] clears at that edge.
- State RELEASE:
  - Every STAGGER_CYCLES cycles, clear rst_out[idx+1] and increment idx.
  - When rst_out[NUM_OUT-1] clears, go to RUN; ready rises on the same edge.
  - With NUM_OUT = 1, HOLD goes directly to RUN.
- Release timing (lock already high at reset release, edge 1 = first rising edge after release):
  - rst_out[k] falls after edge SYNC_STAGES+1+HOLD_CYCLES+k*STAGGER_CYCLES.
- State RUN: outputs all 0, ready = 1.
- Lock loss (lock_s = 0 in HOLD, RELEASE or RUN):
  - Next edge: rst_out = all ones, ready = 0, cause = 1, go to WAIT_LOCK.
- Soft reset (soft_rst = 1 in HOLD, RELEASE or RUN):
  - Next edge: rst_out = all ones, ready = 0, cause = 2, go to HOLD with cnt = 0.
  - soft_rst is ignored in WAIT_LOCK.
- Simultaneous events: lock loss beats soft_rst; soft_rst beats watchdog.
- Release order: rst_out bits are only cleared in index order. No bit is ever cleared while a lower-index bit is still set.
- cause: updates only on a re-assertion event; it is not cleared by entering RUN.
- reset mid-sequence: immediate asynchronous return to the reset values above.

Optional Feature:
- Macro: RESET_SEQ_WDOG_EN.
- Defined:
  - wdog_kick port exists.
  - A watchdog counter runs only in RUN and is cleared by wdog_kick or on leaving RUN.
  - On reaching WDOG_CYCLES-1 without a kick: next edge has rst_out = all ones, ready = 0, cause = 3, go to HOLD.
- Undefined:
  - No port, no counter.
  - cause never reads 3.

Decomposition:
- Shared package reset_seq_pkg:
  - State enum: WAIT_LOCK, HOLD, RELEASE, RUN.
  - Cause code constants: CAUSE_RESET, CAUSE_LOCK, CAUSE_SOFT, CAUSE_WDOG.
- One sub-module, sync_bit: a SYNC_STAGES-deep single-bit synchroniser with async clear, used for pll_locked and reusable elsewhere.

Test Plan:
- Defaults, pll_locked = 1, release reset -> rst_out[0] falls after edge 19, rst_out[1] after 23, rst_out[2] after 27; ready rises with rst_out[2]; cause = 0.
- pll_locked = 0 at reset release, raised at edge 50 -> rst_out stays 3'b111 until edge 50 plus synchroniser latency plus HOLD, then staggers as above.
- In RUN, drop pll_locked for 10 cycles -> within SYNC_STAGES+1 edges rst_out = 3'b111, ready = 0, cause = 1; after relock, full sequence repeats.
- soft_rst pulse during RELEASE with idx = 1 -> next edge rst_out = 3'b111, cause = 2; release restarts after 16 cycles. soft_rst on the same cycle as synchronised lock loss -> cause = 1.
- Assert reset asynchronously mid-HOLD, between clock edges -> rst_out = 3'b111, ready = 0, cause = 0 immediately; no glitch low on any bit.
- RESET_SEQ_WDOG_EN, WDOG_CYCLES = 32:
  - No kick for 32 RUN cycles -> rst_out = 3'b111, cause = 3, re-sequence.
  - Kick every 20 cycles -> no re-assertion.
